// File: rtl/rgmii_inband_status.sv
// Decodes RGMII in-band status seen during inter-frame gaps, debounces it and publishes link/speed/duplex.
// Optional watchdog (adds the stale output) is compiled in when RGMII_INBAND_STALE_EN is defined.
module rgmii_inband_status #(
  parameter int STABLE_CNT   = 16,
  parameter int CW           = 5,
  parameter int STALE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_dv,
  input  logic       rx_er,
  input  logic [7:0] rxd,
  output logic       link_up,
  output logic [1:0] speed,
  output logic       full_duplex,
  output logic       status_valid,
  output logic       status_change,
  output logic [7:0] mismatch_cnt
`ifdef RGMII_INBAND_STALE_EN
  ,
  output logic       stale
`endif
);

  typedef enum logic {ACQUIRE, LOCKED} state_t;

  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CNT);

  if (STABLE_CNT < 2 || (2 ** CW) <= STABLE_CNT || STALE_CYCLES < 1) begin : g_bad_params
    $error("rgmii_inband_status: illegal parameter combination");
  end

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cand;
  logic          w_idle;
  logic          w_valid;
  logic          w_reject;
  logic          w_stable;
  logic          w_publish;
  logic          w_stale_hit;
  logic [3:0]    w_sample;
  logic [3:0]    w_pub;

  // Candidate cycles are true inter-frame gaps; both nibbles must agree and speed 2'b11 is reserved.
  assign w_idle   = !rx_dv && !rx_er;
  assign w_valid  = w_idle && (rxd[7:4] == rxd[3:0]) && (rxd[2:1] != 2'b11);
  assign w_reject = w_idle && !w_valid;
  assign w_sample = {rxd[0], rxd[2:1], rxd[3]};
  assign w_pub    = {link_up, speed, full_duplex};
  assign w_stable = (r_cnt == STABLE_MAX);

`ifdef RGMII_INBAND_STALE_EN
  localparam int SW = $clog2(STALE_CYCLES + 1);

  logic [SW-1:0] r_stale_cnt;

  assign w_stale_hit = !w_valid && (r_stale_cnt == SW'(STALE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stale_cnt <= '0;
      stale       <= 1'b0;
    end else if (w_valid) begin
      r_stale_cnt <= '0;
      stale       <= 1'b0;
    end else begin
      if (r_stale_cnt != SW'(STALE_CYCLES))
        r_stale_cnt <= r_stale_cnt + 1'b1;
      if (w_stale_hit)
        stale <= 1'b1;
    end
  end
`else
  assign w_stale_hit = 1'b0;
`endif

  // The run counter is cleared on a watchdog expiry so reacquisition needs a fresh full run.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_cand <= '0;
    end else if (w_stale_hit || w_reject) begin
      r_cnt <= '0;
    end else if (w_valid) begin
      if (w_sample != r_cand) begin
        r_cand <= w_sample;
        r_cnt  <= CW'(1);
      end else if (!w_stable) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_cnt <= '0;
    end else if (w_reject && (mismatch_cnt != 8'hFF)) begin
      mismatch_cnt <= mismatch_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ACQUIRE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    if (w_stale_hit) begin
      w_state_nxt = ACQUIRE;
    end else begin
      case (r_state)
        ACQUIRE: begin
          if (w_stable) begin
            w_publish   = 1'b1;
            w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (w_stable && (r_cand != w_pub))
            w_publish = 1'b1;
        end
        default: w_state_nxt = ACQUIRE;
      endcase
    end
  end

  // Watchdog expiry keeps speed/duplex but drops link and validity.
  always_ff @(posedge clk) begin
    if (reset) begin
      link_up       <= 1'b0;
      speed         <= 2'b00;
      full_duplex   <= 1'b0;
      status_valid  <= 1'b0;
      status_change <= 1'b0;
    end else begin
      status_change <= 1'b0;
      if (w_stale_hit) begin
        link_up       <= 1'b0;
        status_valid  <= 1'b0;
        status_change <= link_up;
      end else if (w_publish) begin
        {link_up, speed, full_duplex} <= r_cand;
        status_valid  <= 1'b1;
        status_change <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rgmii_inband_status.sv
// Self-checking bench for rgmii_inband_status: vector table, directed sequences and a randomized run against a reference model.
`timescale 1ns/1ps
module tb_rgmii_inband_status;

  localparam int STABLE = 16;
  localparam int STALE  = 100;
`ifdef RGMII_INBAND_STALE_EN
  localparam bit STALE_EN = 1'b1;
`else
  localparam bit STALE_EN = 1'b0;
`endif
  localparam int BURST = STALE_EN ? 90 : 1500;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_dv;
  logic       rx_er;
  logic [7:0] rxd;
  logic       link_up;
  logic [1:0] speed;
  logic       full_duplex;
  logic       status_valid;
  logic       status_change;
  logic [7:0] mismatch_cnt;
  logic       stale_o;

  always #4 clk = ~clk;

  rgmii_inband_status #(
    .STABLE_CNT  (STABLE),
    .CW          (5),
    .STALE_CYCLES(STALE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_dv        (rx_dv),
    .rx_er        (rx_er),
    .rxd          (rxd),
    .link_up      (link_up),
    .speed        (speed),
    .full_duplex  (full_duplex),
    .status_valid (status_valid),
    .status_change(status_change),
    .mismatch_cnt (mismatch_cnt)
`ifdef RGMII_INBAND_STALE_EN
    ,
    .stale        (stale_o)
`endif
  );

`ifndef RGMII_INBAND_STALE_EN
  assign stale_o = 1'b0;
`endif

  int checks    = 0;
  int failures  = 0;
  int n_change  = 0;

  // Reference model: history of valid samples since the last reject/reset.
  logic       m_link, m_dup, m_valid, m_change, m_stale;
  logic [1:0] m_speed;
  logic [7:0] m_mm;
  int         m_since;
  logic [3:0] hist[$];

  typedef struct {
    logic        dv;
    logic        er;
    logic [7:0]  d;
    logic [13:0] exp;
  } vec_t;
  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] act_vec();
    return {stale_o, link_up, speed, full_duplex, status_valid, status_change, mismatch_cnt};
  endfunction

  function automatic logic [14:0] mdl_vec();
    return {m_stale, m_link, m_speed, m_dup, m_valid, m_change, m_mm};
  endfunction

  function automatic int run_len();
    int n;
    n = 0;
    if (hist.size() == 0) return 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == hist[hist.size()-1]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_link = 1'b0; m_speed = 2'b00; m_dup = 1'b0; m_valid = 1'b0;
    m_change = 1'b0; m_stale = 1'b0; m_mm = 8'd0; m_since = 0;
    hist.delete();
  endtask

  task automatic model_step(input logic dv, input logic er, input logic [7:0] d);
    bit         idle, ok, valid, reject, pub, hit;
    logic [3:0] s, tail;
    int         rl;
    idle   = !dv && !er;
    ok     = (d[7:4] == d[3:0]) && (d[2:1] != 2'b11);
    valid  = idle && ok;
    reject = idle && !ok;
    s      = {d[0], d[2:1], d[3]};
    rl     = run_len();
    tail   = (hist.size() > 0) ? hist[hist.size()-1] : 4'h0;
    pub    = (rl >= STABLE) && (!m_valid || (tail != {m_link, m_speed, m_dup}));
    hit    = STALE_EN && !valid && (m_since == STALE - 1);
    m_change = 1'b0;
    if (hit) begin
      m_change = m_link;
      m_link   = 1'b0;
      m_valid  = 1'b0;
      m_stale  = 1'b1;
      hist.delete();
    end else begin
      if (pub) begin
        {m_link, m_speed, m_dup} = tail;
        m_valid  = 1'b1;
        m_change = 1'b1;
      end
      if (reject) hist.delete();
      else if (valid) begin
        hist.push_back(s);
        if (hist.size() > 40) void'(hist.pop_front());
      end
    end
    if (reject && (m_mm != 8'hFF)) m_mm = m_mm + 8'd1;
    if (valid) begin
      m_since = 0;
      m_stale = 1'b0;
    end else if (m_since < STALE) begin
      m_since++;
    end
  endtask

  task automatic cyc(input logic dv, input logic er, input logic [7:0] d);
    rx_dv = dv; rx_er = er; rxd = d;
    @(posedge clk);
    model_step(dv, er, d);
    #1;
    n_change += int'(status_change);
    check("model", 32'(act_vec()), 32'(mdl_vec()));
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    check("reset_state", 32'(act_vec()), 32'd0);
  endtask

  initial begin
    int         c0;
    logic [13:0] a14;
    logic [3:0]  nib;
    int          rl;
    int          k;

    for (int i = 0; i < 17; i++) begin
      tbl[i].dv = 1'b0; tbl[i].er = 1'b0; tbl[i].d = 8'h55;
      tbl[i].exp = (i == 16) ? {1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'd0} : 14'd0;
    end
    tbl[17] = '{dv: 1'b0, er: 1'b0, d: 8'h5D, exp: {1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'd1}};
    tbl[18] = '{dv: 1'b0, er: 1'b1, d: 8'h55, exp: {1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'd1}};
    tbl[19] = '{dv: 1'b1, er: 1'b0, d: 8'h5D, exp: {1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'd1}};

    model_reset();
    do_reset();

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].dv, tbl[i].er, tbl[i].d);
      a14 = {link_up, speed, full_duplex, status_valid, status_change, mismatch_cnt};
      check("table", 32'(a14), 32'(tbl[i].exp));
    end

    // Glitch in the middle of a run restarts qualification.
    c0 = n_change;
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 8'hDD);
    cyc(1'b0, 1'b0, 8'hD5);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 8'hDD);
    check("t2_no_early", 32'(n_change - c0), 32'd0);
    check("t2_hold", 32'({link_up, speed, full_duplex}), 32'(4'b1100));
    cyc(1'b0, 1'b0, 8'hDD);
    check("t2_pub", 32'({link_up, speed, full_duplex}), 32'(4'b1101));
    check("t2_strobes", 32'(n_change - c0), 32'd1);

    // Mismatch saturation.
    c0 = n_change;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 1'b0, 8'h5D);
      if (i % 60 == 59) cyc(1'b0, 1'b0, 8'hDD);
    end
    check("t3_sat", 32'(mismatch_cnt), 32'd255);
    check("t3_outs", 32'({link_up, speed, full_duplex, status_valid}), 32'(5'b11011));
    check("t3_strobes", 32'(n_change - c0), 32'd0);

    // Long frame does not disturb a locked status; then link drop.
    c0 = n_change;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 8'hDD);
    for (int i = 0; i < BURST; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 8'hDD);
    check("t4_quiet", 32'(n_change - c0), 32'd0);
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 8'h00);
    check("t4_down", 32'({link_up, speed, full_duplex}), 32'(4'b0000));
    check("t4_strobes", 32'(n_change - c0), 32'd1);

`ifdef RGMII_INBAND_STALE_EN
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 8'hDD);
    check("t6_lock", 32'(link_up), 32'd1);
    c0 = n_change;
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 8'($urandom));
    check("t6_stale", 32'({stale_o, link_up, status_valid}), 32'(3'b100));
    check("t6_strobe", 32'(n_change - c0), 32'd1);
    check("t6_keep", 32'({speed, full_duplex}), 32'(3'b101));
    cyc(1'b0, 1'b0, 8'hDD);
    check("t6_clear", 32'(stale_o), 32'd0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 8'hDD);
    check("t6_relock", 32'({link_up, status_valid}), 32'(2'b11));
`endif

    // Reset mid-qualification.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 8'hDD);
    do_reset();
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 8'hDD);
    check("t5_15", 32'(status_valid), 32'd0);
    cyc(1'b0, 1'b0, 8'hDD);
    check("t5_16", 32'(status_valid), 32'd0);
    cyc(1'b0, 1'b0, 8'hDD);
    check("t5_pub", 32'({status_valid, link_up}), 32'(2'b11));

    // Randomized runs against the model.
    for (int r = 0; r < 150; r++) begin
      case ($urandom_range(0, 3))
        0:       nib = 4'h5;
        1:       nib = 4'hD;
        2:       nib = 4'h0;
        default: nib = 4'($urandom);
      endcase
      rl = $urandom_range(1, 24);
      for (int j = 0; j < rl; j++) begin
        k = $urandom_range(0, 19);
        if (k == 0)      cyc(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
        else if (k == 1) cyc(1'b0, 1'b1, 8'($urandom));
        else if (k == 2) cyc(1'b0, 1'b0, {~nib, nib});
        else             cyc(1'b0, 1'b0, {nib, nib});
      end
      if (r % 37 == 36) begin
        for (int j = 0; j < 120; j++) cyc(1'b1, 1'b0, 8'($urandom));
      end
      if (r % 50 == 25) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
